// File: rtl/home_auto_pkg.sv
// Shared types and defaults for the home automation blocks.
// Occupancy FSM state encoding and timing defaults.
package home_auto_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONFIRM  = 2'd1,
    OCCUPIED = 2'd2,
    HOLD     = 2'd3
  } occ_state_t;

  localparam int OCC_DEBOUNCE_DEF = 4;
  localparam int OCC_HOLD_DEF     = 16;

endpackage

// File: rtl/occupancy_detector_if.sv
// Sensor-side bundle of the occupancy detector.
// The master drives the sensor inputs; the slave is the detector.
interface occupancy_detector_if;

  logic       motion_raw;
  logic       force_vacant;
  logic       occupied;
  logic       motion_event;
  logic       vacancy_event;
  logic [1:0] state_dbg;

  modport master (
    output motion_raw,
    output force_vacant,
    input  occupied,
    input  motion_event,
    input  vacancy_event,
    input  state_dbg
  );

  modport slave (
    input  motion_raw,
    input  force_vacant,
    output occupied,
    output motion_event,
    output vacancy_event,
    output state_dbg
  );

endinterface

// File: rtl/occupancy_detector_sync.sv
// Generic two-flop synchroniser, async reset to 0.
// Shared with the daylight sensor input.
module bit_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/occupancy_detector.sv
// PIR motion to clean occupancy level with debounce,
// hold-off timer and one-cycle entry/vacancy events.
module occupancy_detector
  import home_auto_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = OCC_DEBOUNCE_DEF,
  parameter int HOLD_CYCLES     = OCC_HOLD_DEF,
  parameter int HOLD_W          = 16
) (
  input  logic clk,
  input  logic rst,
  occupancy_detector_if.slave bus
);

  localparam logic [7:0] DB_LAST =
    8'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(HOLD_CYCLES - 1);

  occ_state_t        state, state_n;
  logic [7:0]        dcnt, dcnt_n;
  logic [HOLD_W-1:0] hcnt, hcnt_n;
  logic              mev_n, vev_n;
  logic              occ_n;
  logic              m_s;

  bit_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.motion_raw),
    .q   (m_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      dcnt              <= '0;
      hcnt              <= '0;
      bus.occupied      <= 1'b0;
      bus.motion_event  <= 1'b0;
      bus.vacancy_event <= 1'b0;
    end else begin
      state             <= state_n;
      dcnt              <= dcnt_n;
      hcnt              <= hcnt_n;
      bus.occupied      <= occ_n;
      bus.motion_event  <= mev_n;
      bus.vacancy_event <= vev_n;
    end
  end

  // Counters only step when a guard proves no wrap is possible.
  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    hcnt_n  = hcnt;
    mev_n   = 1'b0;
    vev_n   = 1'b0;
    if (bus.force_vacant) begin
      state_n = IDLE;
      dcnt_n  = '0;
      hcnt_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (m_s) begin
            state_n = CONFIRM;
            dcnt_n  = 8'd1;
          end
        end
        CONFIRM: begin
          if (!m_s) begin
            state_n = IDLE;
            dcnt_n  = '0;
          end else if (dcnt == DB_LAST) begin
            state_n = OCCUPIED;
            dcnt_n  = '0;
            mev_n   = 1'b1;
          end else begin
            dcnt_n  = dcnt + 8'd1;
          end
        end
        OCCUPIED: begin
          if (!m_s) begin
            state_n = HOLD;
            hcnt_n  = HOLD_LAST;
          end
        end
        HOLD: begin
          if (m_s) begin
            state_n = OCCUPIED;
            hcnt_n  = '0;
          end else if (hcnt == '0) begin
            state_n = IDLE;
            vev_n   = 1'b1;
          end else begin
            hcnt_n  = hcnt - 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    occ_n = (state_n == OCCUPIED) ||
            (state_n == HOLD);
  end

  assign bus.state_dbg = state;

endmodule
